// File: rtl/cipher_out_framer.sv
// Frames the cipher byte stream, appends an XOR-checksum trailer and buffers it in a FWFT FIFO.
// Define CIPHER_FRAMER_LEN_EN to insert a saturating length byte ahead of the checksum trailer.
module cipher_out_framer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] CSUM_INIT = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_char,
  output logic                       m_valid,
  output logic [7:0]                 m_data,
  output logic                       m_last,
  input  logic                       m_ready,
  input  logic                       clear_err,
  output logic                       overflow_err,
  output logic                       proto_err,
  output logic [15:0]                frames_done,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, TRL} state_t;

  state_t          state;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      csum;
`ifdef CIPHER_FRAMER_LEN_EN
  logic [7:0]      len;
`endif

  logic            wr_req;
  logic            wr_trl;
  logic            proto_hit;
  logic [8:0]      wr_data;
  logic            pop;
  logic            accept;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    wr_req    = 1'b0;
    wr_trl    = 1'b0;
    proto_hit = 1'b0;
    wr_data   = 9'd0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          wr_req  = 1'b1;
          wr_data = {1'b0, in_char};
        end
      end
      DATA: begin
        wr_req = 1'b1;
        if (in_valid) begin
          wr_data = {1'b0, in_char};
        end else begin
`ifdef CIPHER_FRAMER_LEN_EN
          wr_data = {1'b0, len};
`else
          wr_data = {1'b1, csum};
          wr_trl  = 1'b1;
`endif
        end
      end
      TRL: begin
        // Trailer-only cycle: any byte arriving now is a contract violation and is discarded.
        wr_req    = 1'b1;
        wr_data   = {1'b1, csum};
        wr_trl    = 1'b1;
        proto_hit = in_valid;
      end
      default: ;
    endcase
  end

  assign m_valid = (fifo_level != '0);
  assign pop     = m_valid && m_ready;
  assign accept  = wr_req && ((fifo_level < LW'(DEPTH)) || pop);
  assign m_data  = m_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign m_last  = m_valid ? mem[rd_ptr][8]   : 1'b0;

  // NOTE: storage is not reset; m_valid gates the head so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      csum         <= CSUM_INIT;
`ifdef CIPHER_FRAMER_LEN_EN
      len          <= 8'd0;
`endif
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
      frames_done  <= 16'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase

      // Error set takes priority over a simultaneous clear.
      if (wr_req && !accept) overflow_err <= 1'b1;
      else if (clear_err)    overflow_err <= 1'b0;
      if (proto_hit)         proto_err    <= 1'b1;
      else if (clear_err)    proto_err    <= 1'b0;

      // A trailer counts as a finished frame even when the FIFO had to drop it.
      if (wr_trl) frames_done <= frames_done + 16'd1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            csum  <= CSUM_INIT ^ in_char;
`ifdef CIPHER_FRAMER_LEN_EN
            len   <= 8'd1;
`endif
            state <= DATA;
          end
        end
        DATA: begin
          if (in_valid) begin
            csum <= csum ^ in_char;
`ifdef CIPHER_FRAMER_LEN_EN
            if (len != 8'hFF) len <= len + 8'd1;
`endif
          end else begin
`ifdef CIPHER_FRAMER_LEN_EN
            state <= TRL;
`else
            state <= IDLE;
`endif
          end
        end
        TRL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_out_framer.sv
// Directed scoreboard bench for cipher_out_framer; adapts expectations to CIPHER_FRAMER_LEN_EN.
module tb_cipher_out_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        clear_err;
  logic        overflow_err;
  logic        proto_err;
  logic [15:0] frames_done;
  logic [4:0]  fifo_level;

  logic [8:0]  exp_q [$];
  int          tests = 0;
  int          fails = 0;

  cipher_out_framer #(.DEPTH(16), .CSUM_INIT(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_char      (in_char),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .clear_err    (clear_err),
    .overflow_err (overflow_err),
    .proto_err    (proto_err),
    .frames_done  (frames_done),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score the handshake about to happen at the next edge, then advance one cycle.
  task automatic cycle();
    logic [8:0] e;
    if (m_valid && m_ready) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_byte", {23'd0, m_last, m_data}, {23'd0, e});
      end else begin
        chk("sb_unexpected", (exp_q.size() != 0), 1);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] c);
    in_valid = v;
    in_char  = c;
    cycle();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) drive(1'b0, 8'h00);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] cs;
    rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; m_ready = 1'b1; clear_err = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    drive(1'b0, 8'h00);

    // Basic frame A5,3C,0F -> checksum 96.
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b0, 8'h0F});
`ifdef CIPHER_FRAMER_LEN_EN
    exp_q.push_back({1'b0, 8'h03});
`endif
    exp_q.push_back({1'b1, 8'h96});
    drive(1'b1, 8'hA5);
    chk("latency_m_valid", m_valid, 1);
    drive(1'b1, 8'h3C);
    drive(1'b1, 8'h0F);
    drain("drain_basic");
    chk("frames_basic", frames_done, 1);

    // Overflow: 20-byte frame with consumer stalled; only the first 16 bytes survive.
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 8'h20 + 8'(i)});
      drive(1'b1, 8'h20 + 8'(i));
    end
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_level", fifo_level, 16);
    chk("ovf_frames", frames_done, 2);
    m_ready = 1'b1;
    drain("drain_ovf");
    chk("ovf_level_empty", fifo_level, 0);
    chk("ovf_frames_after", frames_done, 2);

    clear_err = 1'b1;
    drive(1'b0, 8'h00);
    clear_err = 1'b0;
    chk("ovf_cleared", overflow_err, 0);

    // Full FIFO with simultaneous push and pop: write is accepted.
    m_ready = 1'b0;
    cs = 8'h00;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back({1'b0, 8'h40 + 8'(i)});
      cs = cs ^ (8'h40 + 8'(i));
    end
`ifdef CIPHER_FRAMER_LEN_EN
    exp_q.push_back({1'b0, 8'd17});
`endif
    exp_q.push_back({1'b1, cs});
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h40 + 8'(i));
    chk("full_level", fifo_level, 16);
    m_ready = 1'b1;
    drive(1'b1, 8'h50);
    chk("pushpop_level", fifo_level, 16);
    chk("pushpop_ovf", overflow_err, 0);
    drain("drain_pushpop");
    chk("pushpop_ovf_end", overflow_err, 0);
    chk("frames_pushpop", frames_done, 3);

`ifdef CIPHER_FRAMER_LEN_EN
    // Byte arriving in the trailer-only cycle is discarded and flags proto_err.
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h55});
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    drive(1'b1, 8'hAA);
    chk("proto_set", proto_err, 1);
    drain("drain_proto");
    clear_err = 1'b1;
    drive(1'b0, 8'h00);
    clear_err = 1'b0;
    chk("proto_cleared", proto_err, 0);
`else
    chk("proto_idle", proto_err, 0);
`endif

    // Reset mid-frame: partial frame vanishes, no trailer.
    m_ready = 1'b0;
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_frames", frames_done, 0);
    cycle();
    rst_n = 1'b1;
    m_ready = 1'b1;
    drive(1'b0, 8'h00);
    chk("midrst_no_trailer", m_valid, 0);
    chk("midrst_m_data", m_data, 0);

    exp_q.push_back({1'b0, 8'h11});
`ifdef CIPHER_FRAMER_LEN_EN
    exp_q.push_back({1'b0, 8'h01});
`endif
    exp_q.push_back({1'b1, 8'h11});
    drive(1'b1, 8'h11);
    drain("drain_after_rst");
    chk("frames_after_rst", frames_done, 1);
    chk("final_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cipher_out_framer.md
Name: cipher_out_framer

Overview:
- Sits directly downstream of the AES-Sbox stream cipher stage. Consumes its ciphertext byte stream: dout_ready drives in_valid, txt_out_char drives in_char.
- Groups each contiguous run of valid bytes into a frame and appends an XOR-checksum trailer byte.
- Buffers everything in a FIFO and presents a valid/ready byte stream with a last marker to the next consumer.
- The cipher has no backpressure, so this block absorbs consumer stalls and flags overflow.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4; each entry is 9 bits {last, data}.
CSUM_INIT, 8'h00, checksum seed loaded at reset and at the start of every frame.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  ciphertext byte valid, one byte per cycle, no backpressure
in_char  in  8  ciphertext byte
m_valid  out  1  output byte available
m_data  out  8  output byte (ciphertext or trailer)
m_last  out  1  high on a trailer byte (last byte of frame)
m_ready  in  1  consumer accepts the byte when m_valid && m_ready
clear_err  in  1  synchronous clear of sticky error flags
overflow_err  out  1  sticky: a write was dropped because the FIFO was full
proto_err  out  1  sticky: in_valid arrived during a trailer-only cycle
frames_done  out  16  count of trailers written, wraps at 2^16
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: m_valid=0, m_data=0, m_last=0, overflow_err=0, proto_err=0, frames_done=0, fifo_level=0, FIFO empty, csum=CSUM_INIT, len=0, state=IDLE.
- FSM states and transitions:
  - IDLE: in_valid=1 -> write {0,in_char}; csum=CSUM_INIT^in_char; len=1; go DATA.
  - DATA: in_valid=1 -> write {0,in_char}; csum^=in_char; len=min(len+1,255); stay in DATA.
  - DATA: in_valid=0 (falling edge) -> go TRL.
    - Feature off: write {1,csum} in this same cycle, frames_done++, go IDLE.
  - TRL: only reachable with the feature on (see Optional Feature).
- Writes: at most one FIFO write per cycle.
- Checksum covers all frame bytes, including bytes dropped on overflow.
- Upstream contract: in_valid stays low at least 2 cycles between frames; the cipher guarantees this.
- Any in_valid=1 during a trailer-only cycle: byte discarded, not checksummed, proto_err<=1.
- FIFO is first-word-fall-through:
  - m_valid = level!=0; m_data/m_last show the head entry combinationally from registers.
  - Pop when m_valid && m_ready.
- Write acceptance: a write is accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Full with no pop: write dropped, overflow_err<=1, pointers unchanged. A dropped trailer still increments frames_done.
- Latency: a byte presented at cycle t appears on m_valid at t+1 if the FIFO was empty.
- Pointers wrap modulo DEPTH. fifo_level is updated for simultaneous push+pop (net 0).
- clear_err=1 clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- Reset mid-frame: partial frame discarded, no trailer emitted, FIFO emptied.

Optional Feature:
- Macro CIPHER_FRAMER_LEN_EN.
- Defined: on the DATA falling edge, write {0,len} (frame byte count, saturating at 255) and go TRL. In TRL, write {1,csum}, frames_done++, go IDLE. The trailer is then 2 bytes: length, then checksum. TRL is a trailer-only cycle for proto_err.
- Undefined: single checksum trailer written on the falling-edge cycle; TRL is never entered.
- len and the length byte logic are omitted.

Test Plan:
- Frame 8'hA5,8'h3C,8'h0F on consecutive cycles, m_ready=1 (feature off) -> m_data A5,3C,0F then 96 with m_last=1 on 96 only; frames_done=1.
- Same frame with CIPHER_FRAMER_LEN_EN -> A5,3C,0F,03,96; m_last only on 96.
- m_ready=0, DEPTH=16, 20-byte frame -> 16 bytes held, overflow_err=1, fifo_level=16.
  - Then m_ready=1 -> 16 original bytes drain in order; the trailer was dropped; frames_done=1.
- FIFO full with push and pop in the same cycle -> write accepted; fifo_level stays 16; overflow_err stays 0.
- Feature on, in_valid reasserted the cycle after the falling edge -> that byte discarded, proto_err=1.
  - clear_err pulse -> proto_err=0.
- rst_n low for 1 cycle after 2 of 4 frame bytes -> all outputs return to reset values, no trailer.
  - Next frame 8'h11 -> 11 then trailer 11 (CSUM_INIT=0).
